// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding read, 2-entry buffer.
// Optional Ack timeout with sticky Fault when FETCH_TIMEOUT_EN is defined.
module fetch_controller #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        ReadEnable,
    output logic [31:0] address,
    input  logic        Ack,
    input  logic [31:0] Instr,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    output logic [31:0] InstrOut,
    output logic [31:0] PCOut,
    output logic        Fault
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        IDLE
    } state_t;

    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        discard;
    logic [1:0]  cnt;
    logic [1:0]  cnt_n;
    logic [31:0] ins0, ins1, pc0, pc1;
    logic [31:0] rpc;
    logic        pop, push, tmo;

    assign rpc        = RedirectPC & PC_MASK;
    assign address    = fetch_pc;
    assign InstrValid = (cnt != 2'd0);
    assign InstrOut   = ins0;
    assign PCOut      = pc0;

    assign pop  = InstrValid && !Stall;
    assign push = (state == WAIT) && Ack && !discard && !Redirect;

    always_comb begin
        cnt_n = cnt;
        if (Redirect)
            cnt_n = 2'd0;
        else if (push && !pop)
            cnt_n = cnt + 2'd1;
        else if (!push && pop)
            cnt_n = cnt - 2'd1;
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;
    logic          fault_q;

    assign tmo   = (state == WAIT) && !Ack &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign Fault = fault_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tcnt    <= '0;
            fault_q <= 1'b0;
        end else begin
            if ((state == WAIT) && !Ack && !tmo)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;
            if (tmo)
                fault_q <= 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign Fault = 1'b0;
`endif

    // Buffer: head in slot 0; a push into a 1-deep buffer with a pop lands in slot 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt  <= 2'd0;
            ins0 <= '0;
            ins1 <= '0;
            pc0  <= '0;
            pc1  <= '0;
        end else begin
            cnt <= cnt_n;
            if (!Redirect) begin
                if (pop) begin
                    ins0 <= ins1;
                    pc0  <= pc1;
                end
                if (push) begin
                    if (cnt_n == 2'd2) begin
                        ins1 <= Instr;
                        pc1  <= fetch_pc;
                    end else begin
                        ins0 <= Instr;
                        pc0  <= fetch_pc;
                    end
                end
            end
        end
    end

    // REQ is entered with ReadEnable=0 only straight out of reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= REQ;
            fetch_pc   <= RESET_PC & PC_MASK;
            discard    <= 1'b0;
            ReadEnable <= 1'b0;
        end else begin
            ReadEnable <= 1'b0;
            unique case (state)
                REQ: begin
                    if (Redirect)
                        fetch_pc <= rpc;
                    if (ReadEnable) begin
                        state <= WAIT;
                        if (Redirect)
                            discard <= 1'b1;
                    end else begin
                        ReadEnable <= 1'b1;
                    end
                end
                WAIT: begin
                    if (Ack) begin
                        discard <= 1'b0;
                        if (Redirect) begin
                            fetch_pc   <= rpc;
                            state      <= REQ;
                            ReadEnable <= 1'b1;
                        end else if (discard) begin
                            state      <= REQ;
                            ReadEnable <= 1'b1;
                        end else begin
                            fetch_pc <= fetch_pc + 32'd4;
                            if (cnt_n < 2'd2) begin
                                state      <= REQ;
                                ReadEnable <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else if (Redirect) begin
                        fetch_pc <= rpc;
                        discard  <= 1'b1;
                    end else if (tmo) begin
                        discard    <= 1'b0;
                        state      <= REQ;
                        ReadEnable <= 1'b1;
                    end
                end
                IDLE: begin
                    if (Redirect) begin
                        fetch_pc   <= rpc;
                        state      <= REQ;
                        ReadEnable <= 1'b1;
                    end else if (cnt_n < 2'd2) begin
                        state      <= REQ;
                        ReadEnable <= 1'b1;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a one-cycle-latency memory model.
// Timeout section depends on FETCH_TIMEOUT_EN.
module tb_fetch_controller;

    logic        CLK        = 1'b0;
    logic        RST_N      = 1'b0;
    logic        ReadEnable;
    logic [31:0] address;
    logic        Ack        = 1'b0;
    logic [31:0] Instr      = '0;
    logic        Stall      = 1'b0;
    logic        Redirect   = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        InstrValid;
    logic [31:0] InstrOut;
    logic [31:0] PCOut;
    logic        Fault;

    logic        hold  = 1'b0;
    logic        pend  = 1'b0;
    logic [31:0] paddr = '0;
    int          nreq  = 0;
    int          total = 0;
    int          bad   = 0;

    fetch_controller dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ReadEnable (ReadEnable),
        .address    (address),
        .Ack        (Ack),
        .Instr      (Instr),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .InstrValid (InstrValid),
        .InstrOut   (InstrOut),
        .PCOut      (PCOut),
        .Fault      (Fault)
    );

    always #5 CLK = ~CLK;

    // Memory answers one cycle after a request unless hold is set; word = ~addr
    always @(posedge CLK) begin
        if (!RST_N) begin
            pend <= 1'b0;
            Ack  <= 1'b0;
            nreq <= 0;
        end else begin
            pend  <= ReadEnable ? hold : (pend && hold);
            if (ReadEnable)
                paddr <= address;
            Ack   <= !hold && (ReadEnable || pend);
            Instr <= ~(ReadEnable ? address : paddr);
            nreq  <= nreq + (ReadEnable ? 1 : 0);
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            total++;
            assert (!(ReadEnable && Ack)) else begin
                bad++;
                $error("FAIL re_with_ack obs=%b%b exp=not both", ReadEnable, Ack);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic rst(input logic st, input logic hd);
        @(negedge CLK);
        RST_N    = 1'b0;
        Redirect = 1'b0;
        Stall    = st;
        hold     = hd;
        #1;
        chk("rst_re", ReadEnable, 0);
        chk("rst_addr", address, 32'h0);
        chk("rst_vld", InstrValid, 0);
        chk("rst_instr", InstrOut, 32'h0);
        chk("rst_pc", PCOut, 32'h0);
        chk("rst_fault", Fault, 0);
        cyc(2);
        RST_N = 1'b1;
    endtask

    initial begin
        // Ideal memory: requests at cycles 1,3,5
        rst(1'b0, 1'b0);
        cyc(1);
        chk("t1_c1_re", ReadEnable, 1);
        chk("t1_c1_addr", address, 32'h0);
        cyc(1);
        chk("t1_c2_re", ReadEnable, 0);
        cyc(1);
        chk("t1_c3_re", ReadEnable, 1);
        chk("t1_c3_addr", address, 32'h4);
        chk("t1_c3_vld", InstrValid, 1);
        chk("t1_c3_pc", PCOut, 32'h0);
        chk("t1_c3_ins", InstrOut, 32'hFFFF_FFFF);
        cyc(1);
        chk("t1_c4_vld", InstrValid, 0);
        cyc(1);
        chk("t1_c5_re", ReadEnable, 1);
        chk("t1_c5_addr", address, 32'h8);
        chk("t1_c5_pc", PCOut, 32'h4);
        chk("t1_c5_ins", InstrOut, 32'hFFFF_FFFB);

        // Stall from cycle 0: two fetches then IDLE, then drain
        rst(1'b1, 1'b0);
        cyc(6);
        chk("t2_c6_re", ReadEnable, 0);
        chk("t2_c6_vld", InstrValid, 1);
        chk("t2_c6_pc", PCOut, 32'h0);
        cyc(2);
        chk("t2_nreq", nreq, 2);
        chk("t2_c8_re", ReadEnable, 0);
        Stall = 1'b0;
        cyc(1);
        chk("t2_c9_pc", PCOut, 32'h4);
        chk("t2_c9_re", ReadEnable, 1);
        chk("t2_c9_addr", address, 32'h8);
        cyc(1);
        chk("t2_c10_vld", InstrValid, 0);
        cyc(1);
        chk("t2_c11_vld", InstrValid, 1);
        chk("t2_c11_pc", PCOut, 32'h8);

        // Redirect in WAIT without Ack: stale Ack discarded
        rst(1'b0, 1'b0);
        cyc(3);
        chk("t3_c3_addr", address, 32'h4);
        Stall = 1'b1;
        hold  = 1'b1;
        cyc(1);
        chk("t3_c4_vld", InstrValid, 1);
        chk("t3_c4_re", ReadEnable, 0);
        Redirect   = 1'b1;
        RedirectPC = 32'h100;
        hold       = 1'b0;
        cyc(1);
        chk("t3_c5_vld", InstrValid, 0);
        chk("t3_c5_re", ReadEnable, 0);
        chk("t3_c5_addr", address, 32'h100);
        Redirect = 1'b0;
        Stall    = 1'b0;
        cyc(1);
        chk("t3_c6_re", ReadEnable, 1);
        chk("t3_c6_addr", address, 32'h100);
        chk("t3_c6_vld", InstrValid, 0);
        cyc(2);
        chk("t3_c8_vld", InstrValid, 1);
        chk("t3_c8_pc", PCOut, 32'h100);
        chk("t3_c8_ins", InstrOut, 32'hFFFF_FEFF);

        // Redirect to unaligned 0x203 while Ack is high
        rst(1'b0, 1'b0);
        cyc(2);
        Redirect   = 1'b1;
        RedirectPC = 32'h203;
        cyc(1);
        chk("t4_c3_re", ReadEnable, 1);
        chk("t4_c3_addr", address, 32'h200);
        chk("t4_c3_vld", InstrValid, 0);
        Redirect = 1'b0;
        cyc(2);
        chk("t4_c5_vld", InstrValid, 1);
        chk("t4_c5_pc", PCOut, 32'h200);
        chk("t4_c5_ins", InstrOut, 32'hFFFF_FDFF);
        chk("t4_c5_addr", address, 32'h204);

        // PC wrap from 0xFFFF_FFFC
        rst(1'b0, 1'b0);
        cyc(2);
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFFC;
        cyc(1);
        chk("t5_c3_addr", address, 32'hFFFF_FFFC);
        Redirect = 1'b0;
        cyc(2);
        chk("t5_c5_re", ReadEnable, 1);
        chk("t5_c5_addr", address, 32'h0);
        chk("t5_c5_pc", PCOut, 32'hFFFF_FFFC);
        chk("t5_c5_ins", InstrOut, 32'h3);

        // Redirect in IDLE beats a simultaneous pop
        rst(1'b1, 1'b0);
        cyc(6);
        Redirect   = 1'b1;
        RedirectPC = 32'h40;
        Stall      = 1'b0;
        cyc(1);
        chk("t6_c7_vld", InstrValid, 0);
        chk("t6_c7_re", ReadEnable, 1);
        chk("t6_c7_addr", address, 32'h40);
        Redirect = 1'b0;
        cyc(2);
        chk("t6_c9_vld", InstrValid, 1);
        chk("t6_c9_pc", PCOut, 32'h40);

        // Ack withheld
        rst(1'b0, 1'b1);
`ifdef FETCH_TIMEOUT_EN
        cyc(17);
        chk("t7_c17_fault", Fault, 0);
        chk("t7_c17_re", ReadEnable, 0);
        cyc(1);
        chk("t7_c18_fault", Fault, 1);
        chk("t7_c18_re", ReadEnable, 1);
        chk("t7_c18_addr", address, 32'h0);
        hold = 1'b0;
        cyc(5);
        chk("t7_c23_fault", Fault, 1);
`else
        cyc(25);
        chk("t7_fault", Fault, 0);
        chk("t7_re", ReadEnable, 0);
        chk("t7_addr", address, 32'h0);
        chk("t7_vld", InstrValid, 0);
`endif
        rst(1'b0, 1'b0);
        cyc(1);
        chk("t8_fault_clr", Fault, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000, as the first fetch address after reset.
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 16, as the Ack wait limit used only under REQ-028.
REQ-003 The block SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port ReadEnable  out  1  single-cycle read request to instruction_memory.
REQ-006 The block SHALL have port address  out  32  byte address of the current request.
REQ-007 The block SHALL have port Ack  in  1  one-cycle response pulse from instruction_memory.
REQ-008 The block SHALL have port Instr  in  32  fetched word, valid in the Ack cycle.
REQ-009 The block SHALL have port Stall  in  1  downstream not ready; hold the buffer head.
REQ-010 The block SHALL have port Redirect  in  1  branch/jump flush request.
REQ-011 The block SHALL have port RedirectPC  in  32  new fetch address.
REQ-012 The block SHALL have port InstrValid  out  1  buffer head valid.
REQ-013 The block SHALL have port InstrOut  out  32  buffer head instruction.
REQ-014 The block SHALL have port PCOut  out  32  buffer head PC.
REQ-015 The block SHALL have port Fault  out  1  sticky fetch-timeout flag.

Function
REQ-016 FSM states SHALL be REQ, WAIT and IDLE, with at most one request outstanding.
- REQ: ReadEnable=1 and address=fetchPC for exactly one cycle; next state WAIT.
- WAIT: ReadEnable=0. On Ack, go to REQ if the post-push count is below 2; otherwise go to IDLE.
- IDLE: go to REQ when the count is below 2.
REQ-017 ReadEnable SHALL never be 1 in a cycle where Ack=1, because the responder would drop the Ack; peak rate is therefore one fetch per 2 cycles.
REQ-018 On Ack in WAIT with discard=0, the block SHALL push {Instr, fetchPC} into a 2-entry FIFO and set fetchPC to fetchPC+4, with 32-bit wrap (32'hFFFF_FFFC + 4 = 32'h0).
REQ-019 The block SHALL hold address[1:0] at 2'b00 and force RedirectPC[1:0] to zero.
REQ-020 InstrValid SHALL be 1 exactly when the FIFO is non-empty, with InstrOut and PCOut driven from the FIFO head.
REQ-021 The block SHALL pop the FIFO when InstrValid=1 and Stall=0; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-022 On Redirect=1 the block SHALL flush the FIFO and set fetchPC to RedirectPC.
- If that cycle is REQ, or is WAIT without Ack, discard SHALL be set and the next state SHALL be WAIT.
- If that cycle is WAIT with Ack, the Ack SHALL be dropped and the next state SHALL be REQ.
- If that cycle is IDLE, the next state SHALL be REQ.
REQ-023 When discard=1, the block SHALL drop the next Ack without pushing or advancing fetchPC, clear discard, and go to REQ.
REQ-024 Redirect SHALL take priority over both push and pop in the same cycle.
REQ-025 Ack received outside WAIT SHALL be ignored.

Reset
REQ-026 While RST_N=0 the block SHALL immediately force state=REQ, fetchPC=RESET_PC, FIFO empty, discard=0, ReadEnable=0, address=RESET_PC, InstrValid=0, InstrOut=0, PCOut=0 and Fault=0.
REQ-027 After RST_N deasserts, the first rising edge SHALL enter REQ with ReadEnable=1 and address=RESET_PC; an in-flight request abandoned by reset SHALL be ignored under REQ-025.

Configuration
REQ-028 With macro FETCH_TIMEOUT_EN defined, the block SHALL count WAIT cycles without Ack.
- At TIMEOUT_CYCLES, it SHALL set Fault=1, which stays set until reset.
- It SHALL then re-enter REQ with the same fetchPC.
REQ-029 Without FETCH_TIMEOUT_EN, the block SHALL tie Fault to 0, include no counter logic, and remain in WAIT indefinitely.

Verification
REQ-030 Reset release with RESET_PC=0 and an ideal memory -> ReadEnable pulses at cycles 1, 3, 5 with addresses 0x0, 0x4, 0x8; InstrValid first high at cycle 3 with PCOut=0x0.
REQ-031 Stall held high from cycle 0 -> exactly 2 requests issued, then IDLE with ReadEnable=0; releasing Stall drains 0x0 then 0x4 and fetch resumes at 0x8.
REQ-032 Redirect to 0x100 in a WAIT cycle without Ack -> the next Ack is discarded, the FIFO is empty, the next request is address 0x100, and PCOut is 0x100 when it becomes valid.
REQ-033 Redirect to 0x203 while Ack is high -> Instr is dropped and the next request is address 0x200.
REQ-034 Starting at fetchPC=0xFFFF_FFFC -> the next request address is 0x0000_0000.
REQ-035 With FETCH_TIMEOUT_EN and Ack withheld -> Fault=1 after 16 WAIT cycles, the same address is re-requested, and Fault stays 1 until RST_N=0.
